// File: rtl/trig_pattern_gen.sv
// trig_pattern_gen: mask/value/edge pattern matcher over synchronized channel
// inputs. Counts qualifying matches while armed and emits a single-cycle
// trigger pulse on the Nth match. Configured through a byte-wide write port
// that is only honoured while the block is idle.
module trig_pattern_gen #(
    parameter int unsigned CH   = 8,
    parameter int unsigned CNTW = 8
) (
    input  logic                                CLK,
    input  logic                                nRST,
    input  logic                                ENTrig,
    input  logic [CH-1:0]                       din,
    input  logic [1:0]                          cfg_sel,
    input  logic [((CH > CNTW) ? CH : CNTW)-1:0] cfg_data,
    input  logic                                cfg_we,
    output logic                                trig,
    output logic                                armed,
    output logic [CNTW-1:0]                     hits
);

    localparam int unsigned DW = (CH > CNTW) ? CH : CNTW;

    localparam logic [1:0] SEL_MASK  = 2'd0;
    localparam logic [1:0] SEL_VALUE = 2'd1;
    localparam logic [1:0] SEL_EDGE  = 2'd2;
    localparam logic [1:0] SEL_OCC   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_WAIT  = 3'd2,
        S_FIRED = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Input synchronizer, previous-sample and registered match
    logic [CH-1:0]   r_sync1;
    logic [CH-1:0]   r_sync2;
    logic [CH-1:0]   r_prev;
    logic            r_match;

    // Pattern configuration
    logic [CH-1:0]   r_mask;
    logic [CH-1:0]   r_value;
    logic [CH-1:0]   r_edge;
    logic [CNTW-1:0] r_occ;

    // Control state and registered outputs
    state_t          r_state;
    logic [CNTW-1:0] r_hits;
    logic            r_trig;
    logic            r_armed;

    // Combinational helpers
    logic [CH-1:0]   w_ch_match;
    logic            w_match;
    logic [CNTW-1:0] w_occ_wr;
    logic [CNTW-1:0] w_hits_inc;
    logic            w_last_hit;
    logic            w_cfg_ok;

    // Per-channel match: masked-off channels are don't-care; edge channels
    // additionally require a transition into the programmed value.
    always_comb begin
        w_ch_match = ~r_mask
                   | (~(r_sync2 ^ r_value) & (~r_edge | (r_prev ^ r_sync2)));
        w_match    = (&w_ch_match) & (|r_mask);
    end

    // Occurrence write value (zero is promoted to one) and hit bookkeeping
    always_comb begin
        w_occ_wr   = cfg_data[CNTW-1:0];
        if (w_occ_wr == '0) begin
            w_occ_wr = CNTW'(1);
        end
        w_hits_inc = r_hits + CNTW'(1);
        w_last_hit = (w_hits_inc == r_occ);
        w_cfg_ok   = cfg_we & (r_state == S_IDLE);
    end

    // Two-flop synchronizer; prev follows s2 every cycle so that the ARM
    // cycle leaves prev equal to the current sample (no stale edge).
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_match <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_match <= w_match;
        end
    end

    // Configuration registers, writable only while idle
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_mask  <= '0;
            r_value <= '0;
            r_edge  <= '0;
            r_occ   <= CNTW'(1);
        end else if (w_cfg_ok) begin
            case (cfg_sel)
                SEL_MASK:  r_mask  <= cfg_data[CH-1:0];
                SEL_VALUE: r_value <= cfg_data[CH-1:0];
                SEL_EDGE:  r_edge  <= cfg_data[CH-1:0];
                SEL_OCC:   r_occ   <= w_occ_wr;
                default:   r_occ   <= r_occ;
            endcase
        end
    end

    // Arm/count/fire state machine; trig and armed are registered with the
    // state so they reflect the state being entered.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_hits  <= '0;
            r_trig  <= 1'b0;
            r_armed <= 1'b0;
        end else if (!ENTrig) begin
            // Disarm wins from every state; hits is left for inspection
            r_state <= S_IDLE;
            r_trig  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_trig  <= 1'b0;
            r_armed <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state <= S_ARM;
                    r_hits  <= '0;
                    r_armed <= 1'b1;
                end
                S_ARM: begin
                    // Match result from before arming is discarded here
                    r_state <= S_WAIT;
                    r_armed <= 1'b1;
                end
                S_WAIT: begin
                    if (r_match && w_last_hit) begin
                        r_state <= S_FIRED;
                        r_trig  <= 1'b1;
                    end else begin
                        if (r_match) begin
                            r_hits <= w_hits_inc;
                        end
                        r_armed <= 1'b1;
                    end
                end
                S_FIRED: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign trig  = r_trig;
    assign armed = r_armed;
    assign hits  = r_hits;

    // DW only sizes the write port; referenced to keep the width explicit
    logic [DW-1:0] w_cfg_data_unused;
    assign w_cfg_data_unused = cfg_data;

endmodule
